// File: rtl/pingpong_block_buffer_pkg.sv
// pingpong_pkg: shared geometry defaults, bank select type and sizing helpers
// for the ping-pong block buffer and its raster address generator.
package pingpong_pkg;

    // Default screen geometry: 640x480 pixels split into 16x20 pixel blocks.
    localparam int DEF_BLOCK_W  = 16;
    localparam int DEF_BLOCK_H  = 20;
    localparam int DEF_BLOCKS_H = 40;
    localparam int DEF_BLOCKS_V = 24;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_t;

    function automatic int calc_depth(input int blocks_h, input int blocks_v);
        return blocks_h * blocks_v;
    endfunction

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pingpong_block_buffer_raster_block_counter.sv
// raster_block_counter: pixel/column/line/row raster counters that turn a
// stream of pixel strobes into a row-major block address.
//   clk, rst : clock, asynchronous active-low reset
//   sof_i    : start of frame, restarts the raster at pixel (0,0)
//   en_i     : one pixel consumed, advances the raster
//   addr_o   : block address of the pixel consumed this cycle
module raster_block_counter #(
    parameter int BLOCK_W  = 16,
    parameter int BLOCK_H  = 20,
    parameter int BLOCKS_H = 40,
    parameter int BLOCKS_V = 24,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof_i,
    input  logic          en_i,
    output logic [AW-1:0] addr_o
);

    localparam int PXW = (BLOCK_W  > 1) ? $clog2(BLOCK_W)  : 1;
    localparam int CLW = (BLOCKS_H > 1) ? $clog2(BLOCKS_H) : 1;
    localparam int LNW = (BLOCK_H  > 1) ? $clog2(BLOCK_H)  : 1;
    localparam int RWW = (BLOCKS_V > 1) ? $clog2(BLOCKS_V) : 1;

    logic [PXW-1:0] px_q, px_d, px_b;
    logic [CLW-1:0] col_q, col_d, col_b;
    logic [LNW-1:0] ln_q, ln_d, ln_b;
    logic [RWW-1:0] row_q, row_d, row_b;
    // base_q tracks row*BLOCKS_H incrementally so no multiplier is needed.
    logic [AW-1:0]  base_q, base_d, base_b;

    always_comb begin
        // sof restarts the raster before this cycle's pixel is addressed.
        px_b   = sof_i ? '0 : px_q;
        col_b  = sof_i ? '0 : col_q;
        ln_b   = sof_i ? '0 : ln_q;
        row_b  = sof_i ? '0 : row_q;
        base_b = sof_i ? '0 : base_q;

        px_d   = px_b;
        col_d  = col_b;
        ln_d   = ln_b;
        row_d  = row_b;
        base_d = base_b;

        if (en_i) begin
            if (px_b == PXW'(BLOCK_W - 1)) begin
                px_d = '0;
                if (col_b == CLW'(BLOCKS_H - 1)) begin
                    col_d = '0;
                    if (ln_b == LNW'(BLOCK_H - 1)) begin
                        ln_d = '0;
                        if (row_b == RWW'(BLOCKS_V - 1)) begin
                            row_d  = '0;
                            base_d = '0;
                        end else begin
                            row_d  = row_b + 1'b1;
                            base_d = base_b + AW'(BLOCKS_H);
                        end
                    end else begin
                        ln_d = ln_b + 1'b1;
                    end
                end else begin
                    col_d = col_b + 1'b1;
                end
            end else begin
                px_d = px_b + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_q   <= '0;
            col_q  <= '0;
            ln_q   <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            px_q   <= px_d;
            col_q  <= col_d;
            ln_q   <= ln_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    assign addr_o = base_b + AW'(col_b);

endmodule

// File: rtl/pingpong_block_buffer.sv
// pingpong_block_buffer: double-buffered block-resolution frame store. The
// writer fills one bank with one value per screen block while the raster
// reader scans the other bank; banks swap at reader start-of-frame only when
// a complete frame has been written, otherwise the last frame is repeated.
//   clk, rst                 : clock, asynchronous active-low reset
//   wr_valid/wr_ready        : write handshake (ready low once a frame is complete)
//   wr_addr/wr_data/wr_last  : row-major block index, value, final write of frame
//   rd_sof, rd_en            : reader start-of-frame and pixel strobes
//   rd_data/rd_valid         : block value for the pixel, one cycle after rd_en
//   swap, repeat_frame       : one-cycle pulses reporting the rd_sof decision
//   wr_err                   : sticky, an accepted write had an out-of-range address
module pingpong_block_buffer
    import pingpong_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int BLOCK_H  = DEF_BLOCK_H,
    parameter int BLOCKS_H = DEF_BLOCKS_H,
    parameter int BLOCKS_V = DEF_BLOCKS_V,
    parameter int DEPTH    = calc_depth(BLOCKS_H, BLOCKS_V),
    parameter int AW       = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_sof,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              swap,
    output logic              repeat_frame,
    output logic              wr_err
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    bank_sel_t wr_bank_q, wr_bank_d;
    bank_sel_t rd_bank;
    logic      full_q, full_d;
    logic      primed_q, primed_d;
    logic      wr_err_q, wr_err_d;
    logic      swap_q, swap_d;
    logic      rpt_q, rpt_d;
    logic      rd_valid_q;

    logic      wr_acc, wr_in_range, wr_we, full_eff;
    logic [AW-1:0] rd_addr;

    assign wr_acc      = wr_valid & ~full_q;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign wr_we       = wr_acc & wr_in_range;
    // A wr_last accepted in the rd_sof cycle already counts as a complete frame.
    assign full_eff    = full_q | (wr_acc & wr_last);

    always_comb begin
        wr_bank_d = wr_bank_q;
        full_d    = full_eff;
        primed_d  = primed_q;
        wr_err_d  = wr_err_q | (wr_acc & ~wr_in_range);
        swap_d    = 1'b0;
        rpt_d     = 1'b0;
        if (rd_sof) begin
            if (full_eff) begin
                wr_bank_d = bank_sel_t'(~wr_bank_q);
                full_d    = 1'b0;
                primed_d  = 1'b1;
                swap_d    = 1'b1;
            end else begin
                rpt_d = 1'b1;
            end
        end
    end

    // Reads in the rd_sof cycle use the post-decision bank and primed state.
    assign rd_bank = bank_sel_t'(~wr_bank_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q  <= BANK_0;
            full_q     <= 1'b0;
            primed_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            swap_q     <= 1'b0;
            rpt_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            primed_q   <= primed_d;
            wr_err_q   <= wr_err_d;
            swap_q     <= swap_d;
            rpt_q      <= rpt_d;
            rd_valid_q <= rd_en;
        end
    end

    raster_block_counter #(
        .BLOCK_W  (BLOCK_W),
        .BLOCK_H  (BLOCK_H),
        .BLOCKS_H (BLOCKS_H),
        .BLOCKS_V (BLOCKS_V),
        .AW       (AW)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .sof_i  (rd_sof),
        .en_i   (rd_en),
        .addr_o (rd_addr)
    );

    // Two plain arrays, each with one synchronous write and one registered
    // read, so each maps onto a block RAM. Contents are not reset.
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk) begin
        if (wr_we && wr_bank_q == BANK_0) mem0[wr_addr] <= wr_data;
        if (wr_we && wr_bank_q == BANK_1) mem1[wr_addr] <= wr_data;
        if (rd_en) begin
            rd0_q <= mem0[rd_addr];
            rd1_q <= mem1[rd_addr];
        end
    end

    // Bank select and primed mask are captured with the read so rd_data holds
    // while rd_en is low, and reset masks stale RAM output immediately.
    bank_sel_t rd_sel_q;
    logic      rd_live_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel_q  <= BANK_0;
            rd_live_q <= 1'b0;
        end else if (rd_en) begin
            rd_sel_q  <= rd_bank;
            rd_live_q <= primed_d;
        end
    end

    assign rd_data      = !rd_live_q ? '0 : ((rd_sel_q == BANK_1) ? rd1_q : rd0_q);
    assign rd_valid     = rd_valid_q;
    assign wr_ready     = ~full_q;
    assign swap         = swap_q;
    assign repeat_frame = rpt_q;
    assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_pingpong_block_buffer.sv
// Bench for pingpong_block_buffer with a reduced pixel geometry (4x2 pixel
// blocks, 40x24 blocks) so full frames fit in a short run; the block count
// (960) matches the default so the address-based expectations are unchanged.
module tb_pingpong_block_buffer;

    localparam int DW        = 8;
    localparam int BW        = 4;
    localparam int BH        = 2;
    localparam int BHN       = 40;
    localparam int BVN       = 24;
    localparam int DEPTH     = BHN * BVN;
    localparam int AW        = 10;
    localparam int LINE_PIX  = BW * BHN;
    localparam int FRAME_PIX = LINE_PIX * BH * BVN;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          rd_sof;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          swap;
    logic          repeat_frame;
    logic          wr_err;

    pingpong_block_buffer #(
        .DATA_W   (DW),
        .BLOCK_W  (BW),
        .BLOCK_H  (BH),
        .BLOCKS_H (BHN),
        .BLOCKS_V (BVN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_sof       (rd_sof),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .swap         (swap),
        .repeat_frame (repeat_frame),
        .wr_err       (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_wrbank, m_full, m_primed, m_err;
    int            m_p;
    logic [DW-1:0] mmem [2][DEPTH];
    logic [DW-1:0] e_data;
    bit            e_valid, e_swap, e_rpt, e_ready, e_err;
    bit            chk_en = 1'b0;

    function automatic int pix_addr(input int p);
        return (p / (LINE_PIX * BH)) * BHN + (p % LINE_PIX) / BW;
    endfunction

    task automatic model_reset();
        m_wrbank = 0; m_full = 0; m_primed = 0; m_err = 0; m_p = 0;
        e_data = '0; e_valid = 0; e_swap = 0; e_rpt = 0; e_ready = 1; e_err = 0;
    endtask

    task automatic model_step();
        bit acc, feff, nb, np;
        if (!rst) begin
            model_reset();
            return;
        end
        acc  = wr_valid && !m_full;
        feff = m_full || (acc && wr_last);
        nb = m_wrbank;
        np = m_primed;
        e_swap = 0;
        e_rpt  = 0;
        if (rd_sof) begin
            m_p = 0;
            if (feff) begin nb = !m_wrbank; np = 1; e_swap = 1; end
            else e_rpt = 1;
        end
        m_full  = (rd_sof && feff) ? 1'b0 : feff;
        e_valid = rd_en;
        if (rd_en) begin
            e_data = np ? mmem[!nb][pix_addr(m_p)] : '0;
            m_p = (m_p + 1) % FRAME_PIX;
        end
        if (acc) begin
            if (int'(wr_addr) < DEPTH) mmem[m_wrbank][wr_addr] = wr_data;
            else m_err = 1;
        end
        m_wrbank = nb;
        m_primed = np;
        e_ready  = !m_full;
        e_err    = m_err;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data", 32'(rd_data), 32'(e_data));
            check("rd_valid", 32'(rd_valid), 32'(e_valid));
            check("swap", 32'(swap), 32'(e_swap));
            check("repeat_frame", 32'(repeat_frame), 32'(e_rpt));
            check("wr_ready", 32'(wr_ready), 32'(e_ready));
            check("wr_err", 32'(wr_err), 32'(e_err));
        end
    end

    task automatic cycle(input logic sof, input logic en, input logic wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic wl);
        rd_sof = sof; rd_en = en; wr_valid = wv; wr_addr = wa; wr_data = wd; wr_last = wl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    logic [DW-1:0] fdata [DEPTH];

    task automatic new_frame_data();
        for (int i = 0; i < DEPTH; i++) fdata[i] = DW'($urandom);
    endtask

    // Write a whole frame of fdata with random gaps while optionally reading.
    task automatic write_frame(input bit rd_rand);
        int  wptr = 0;
        bit  wv, acc;
        while (wptr < DEPTH) begin
            wv  = ($urandom_range(3) != 0);
            acc = wv && !m_full;
            cycle(1'b0, rd_rand ? 1'($urandom_range(1)) : 1'b0, wv, AW'(wptr), fdata[wptr],
                  wptr == DEPTH - 1);
            if (acc) wptr++;
        end
    endtask

    initial begin
        int  wptr;
        bit  wv, acc;
        logic [DW-1:0] c0;

        rst = 1'b0;
        rd_sof = 0; rd_en = 0; wr_valid = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // reset state
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_wr_err", 32'(wr_err), 32'd0);

        // rd_sof with nothing written: repeat, unprimed zeros
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("unprimed_repeat", 32'(repeat_frame), 32'd1);
        check("unprimed_no_swap", 32'(swap), 32'd0);
        repeat (40) cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        check("unprimed_data", 32'(rd_data), 32'd0);

        // frame A: data = addr[7:0]
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b0, 1'b1, AW'(i), DW'(i), i == DEPTH - 1);
        check("ready_after_last", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b0, 1'b1, AW'(i * 7), 8'hEE, 1'b0);

        // read frame A completely while frame B is written (and extra writes dropped)
        new_frame_data();
        wptr = 0;
        for (int k = 0; k < FRAME_PIX; k++) begin
            wv  = ($urandom_range(3) != 0);
            acc = wv && !m_full;
            cycle(k == 0, 1'b1, wv,
                  (wptr < DEPTH) ? AW'(wptr) : AW'($urandom_range(DEPTH - 1)),
                  (wptr < DEPTH) ? fdata[wptr] : 8'hA5, wptr == DEPTH - 1);
            if (acc) wptr++;
            if (k == 0) check("frameA_swap", 32'(swap), 32'd1);
            if (k < BW) check("frameA_line0", 32'(rd_data), 32'd0);
            if (k == BW) check("frameA_pix_bw", 32'(rd_data), 32'd1);
            if (k == LINE_PIX * BH) check("frameA_row1", 32'(rd_data), 32'd40);
            if (k == FRAME_PIX - 1) check("frameA_last", 32'(rd_data), 32'hBF);
        end

        // frame B read with gaps; frame C written except its last block
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("frameB_swap", 32'(swap), 32'd1);
        new_frame_data();
        wptr = 0;
        for (int k = 0; k < 3000; k++) begin
            wv  = (wptr < DEPTH - 1) && ($urandom_range(3) != 0);
            acc = wv && !m_full;
            cycle(1'b0, 1'($urandom_range(1)), wv, AW'(wptr), fdata[wptr], 1'b0);
            if (acc) wptr++;
        end
        while (wptr < DEPTH - 1) begin
            cycle(1'b0, 1'b1, 1'b1, AW'(wptr), fdata[wptr], 1'b0);
            wptr++;
        end
        // wr_last in the rd_sof cycle: swap now, pixel (0,0) from frame C
        c0 = fdata[0];
        cycle(1'b1, 1'b1, 1'b1, AW'(DEPTH - 1), fdata[DEPTH - 1], 1'b1);
        check("sof_last_swap", 32'(swap), 32'd1);
        check("sof_last_pix0", 32'(rd_data), 32'(c0));

        // read C, then sof without a complete frame repeats C
        repeat (2000) cycle(1'b0, 1'($urandom_range(1)), 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("repeat_no_swap", 32'(swap), 32'd0);
        check("repeat_pulse", 32'(repeat_frame), 32'd1);
        check("repeat_pix0", 32'(rd_data), 32'(c0));

        // out-of-range write: sticky error, nothing stored
        cycle(1'b0, 1'b1, 1'b1, AW'(DEPTH), 8'h55, 1'b0);
        check("wr_err_set", 32'(wr_err), 32'd1);
        repeat (500) cycle(1'b0, 1'($urandom_range(1)), 1'b0, '0, '0, 1'b0);
        check("wr_err_sticky", 32'(wr_err), 32'd1);

        // frame D, swap, read while frame E completes, then reset mid-frame
        new_frame_data();
        write_frame(1'b1);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        new_frame_data();
        write_frame(1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        check("pre_reset_ready", 32'(wr_ready), 32'd0);
        #2;
        rst = 1'b0;
        rd_en = 1'b0;
        model_reset();
        #1;
        check("mid_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_reset_rd_data", 32'(rd_data), 32'd0);
        check("mid_reset_wr_ready", 32'(wr_ready), 32'd1);
        check("mid_reset_wr_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // after reset: repeat and zeros until a new completed swap
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("post_reset_repeat", 32'(repeat_frame), 32'd1);
        repeat (100) cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        check("post_reset_zero", 32'(rd_data), 32'd0);
        new_frame_data();
        write_frame(1'b1);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("post_reset_swap", 32'(swap), 32'd1);
        check("post_reset_pix0", 32'(rd_data), 32'(fdata[0]));
        repeat (400) cycle(1'b0, 1'($urandom_range(1)), 1'b0, '0, '0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/pingpong_block_buffer.md
# pingpong_block_buffer

- Parametrised double-buffered block-resolution frame store between the block-averaging writer and the VGA raster reader.
- Writer fills one bank with one value per screen block while the reader scans the other bank at pixel rate.
- Banks swap only at reader start-of-frame, and only when the writer has delivered a complete frame; otherwise the last complete frame is repeated.
- Read addresses are generated internally from raster counters, so the reader supplies strobes only, not coordinates.

## Interface
Parameters:
- DATA_W, 8, bits per stored block value
- BLOCK_W, 16, screen pixels per block horizontally
- BLOCK_H, 20, screen lines per block vertically
- BLOCKS_H, 40, blocks per row
- BLOCKS_V, 24, block rows per frame
- DEPTH, BLOCKS_H*BLOCKS_V (derived), entries per bank
- AW, $clog2(DEPTH) (derived), address width

Ports:
- clk  in  1  single clock for both sides
- rst  in  1  asynchronous, active-low reset
- wr_valid  in  1  write strobe
- wr_ready  out  1  write bank accepting data
- wr_addr  in  AW  block index, row-major
- wr_data  in  DATA_W  block value
- wr_last  in  1  qualifies final write of a frame
- rd_sof  in  1  reader start-of-frame strobe
- rd_en  in  1  one active pixel consumed
- rd_data  out  DATA_W  block value for the pixel
- rd_valid  out  1  rd_data valid
- swap  out  1  pulse: banks swapped at this rd_sof
- repeat_frame  out  1  pulse: rd_sof with no complete frame, old bank kept
- wr_err  out  1  sticky: accepted write had wr_addr >= DEPTH

## Operation
- State:
  - wr_bank, 1 bit; the read bank is ~wr_bank.
  - full, 1 bit.
  - primed, 1 bit; set on first swap.
  - Raster counters: px (0..BLOCK_W-1), col (0..BLOCKS_H-1), ln (0..BLOCK_H-1), row (0..BLOCKS_V-1).
- Write side:
  - wr_ready = !full.
  - A write is accepted when wr_valid && wr_ready. An accepted write with wr_addr < DEPTH stores into bank wr_bank.
  - An accepted write with wr_addr >= DEPTH is discarded and sets wr_err.
  - A write with wr_ready low is dropped silently.
  - An accepted write with wr_last high sets full, even when the address is out of range.
- Swap decision at rd_sof:
  - full_eff = full OR (accepted wr_last this cycle).
  - If full_eff: toggle wr_bank, clear full, set primed, pulse swap.
  - Else: pulse repeat_frame; wr_bank and full are unchanged.
  - rd_sof also zeroes all raster counters.
- Read side:
  - Read address = row*BLOCKS_H + col, computed from counters with no division.
  - Each rd_en advances px. On px wrap, col advances. On col wrap, ln advances and col returns to 0. On ln wrap, row advances. row wraps to 0.
  - When rd_sof and rd_en are high in the same cycle, the read is pixel (0,0) from the bank that is the read bank after the swap decision.
  - rd_data is forced to 0 while primed = 0.

## Timing
- Reset values: wr_bank=0, full=0, primed=0, all counters 0, rd_data=0, rd_valid=0, swap=0, repeat_frame=0, wr_err=0, wr_ready=1.
- Read latency is 1 cycle: rd_valid(t+1) = rd_en(t), and rd_data is registered.
- With rd_en low, rd_valid is low and rd_data holds its value.
- swap and repeat_frame are registered single-cycle pulses, asserted the cycle after rd_sof.
- wr_ready falls the cycle after an accepted wr_last, and rises the cycle after the swap edge.
- A write accepted in the rd_sof cycle goes to the pre-swap wr_bank.
- Reset asserted mid-frame: all state returns to reset values immediately. RAM contents are undefined, and are masked because primed = 0.
- The memory arrays are not reset and must infer synchronous block RAM: one write port on the write bank, one read port on the read bank.

## Structure
- Package pingpong_pkg holds:
  - default geometry constants (BLOCK_W, BLOCK_H, BLOCKS_H, BLOCKS_V);
  - a bank_sel_t typedef;
  - a function for DEPTH and AW.
- Sub-module raster_block_counter contains the px/col/ln/row counters and address generation. Its inputs are sof and en; its output is the block address.
- The top level contains the bank state, the two RAM arrays and the output registers.

## Test plan
- Reset then rd_sof with no writes -> repeat_frame pulses once, and every rd_data is 0 (unprimed).
- Write all 960 blocks with data = addr[7:0], wr_last on addr 959, then rd_sof with one full frame of rd_en:
  - swap pulses;
  - the 16 pixels of line 0 read 0;
  - pixel 16 reads 1;
  - line 20, pixel 0 reads 40;
  - final pixel reads 959[7:0] = 0xBF.
- Second frame written while frame 1 is read: read data stays frame 1 until the next rd_sof, then switches. Writes after wr_last (wr_ready=0) do not alter either bank.
- wr_last accepted in the same cycle as rd_sof -> swap, and pixel (0,0) of that cycle comes from the new frame.
- Write at wr_addr = 960 -> wr_err set and stays set; bank contents are unchanged.
- Reset asserted mid-frame -> all outputs return to reset values in the same cycle, and rd_data reads 0 until the next completed swap.
